// File: rtl/round_robin_scheduler.sv
// -----------------------------------------------------------------------------
// round_robin_scheduler
//
// Hardware round-robin process scheduler for a multiprogrammed CPU. It holds
// the process table (slot state plus saved PC) and counts the time slice in
// retired instructions. It preempts on quantum expiry, on a blocking IN, or
// at process end. It then drives the CPU PC-load path with the saved PC of
// the next process.
//
// Optional feature macro: SCHED_STATS_EN
//   defined   -> switch_count counts dispatches (saturating at 65535) and
//                clears on reset and on an accepted start
//   undefined -> switch_count is tied to zero and no counter is built
//
// Ports:
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high; clears all state
//   start        in   1   admit nproc processes and begin scheduling
//   nproc        in   4   process count, sampled on start (clamped to NPROC)
//   step         in   1   CPU retires the instruction at pc this cycle
//   pc           in  32   current CPU PC
//   io_wait      in   1   current instruction is a blocking IN
//   io_done      in   1   input available; unblocks lowest blocked slot
//   proc_end     in   1   current instruction ends the process
//   hold         out  1   combinational; CPU must not update PC
//   switch_req   out  1   one-cycle pulse; CPU loads new_pc
//   new_pc       out 32   saved PC of the dispatched process
//   proc_id      out  4   running process id, 0 when none
//   running      out  1   scheduler is in RUN
//   all_done     out  1   every admitted process has finished
//   switch_count out 16   dispatch counter (see macro above)
// -----------------------------------------------------------------------------
module round_robin_scheduler #(
  parameter int NPROC   = 10,
  parameter int QUANTUM = 16,
  parameter int BASE    = 300,
  parameter int SLOT    = 300
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  nproc,
  input  logic        step,
  input  logic [31:0] pc,
  input  logic        io_wait,
  input  logic        io_done,
  input  logic        proc_end,
  output logic        hold,
  output logic        switch_req,
  output logic [31:0] new_pc,
  output logic [3:0]  proc_id,
  output logic        running,
  output logic        all_done,
  output logic [15:0] switch_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_DISPATCH, S_RUN, S_WAIT, S_DONE
  } sched_state_e;

  typedef enum logic [1:0] {
    SLOT_FREE, SLOT_READY, SLOT_BLOCKED, SLOT_FINISHED
  } slot_state_e;

  sched_state_e state_q, state_d;

  slot_state_e  slot_state [1:NPROC];
  logic [31:0]  saved_pc   [1:NPROC];

  logic [3:0]   n_q;        // admitted process count
  logic [3:0]   cur_q;      // last dispatched id; rotation starts after it
  logic [3:0]   proc_id_q;
  logic [31:0]  new_pc_q;
  logic [7:0]   quantum_q;  // instructions left in the current slice

  logic [3:0]   n_start;
  logic [4:0]   cand;
  logic         sel_found;
  logic [3:0]   sel_id;
  logic         any_ready;
  logic         any_blocked;
  logic [3:0]   unblk_id;
  logic         run_event;
  logic         admit;

  assign n_start = (nproc > 4'(NPROC)) ? 4'(NPROC) : nproc;
  assign admit   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // A preempting event: end, blocking IN, or the step after the slice is used.
  assign run_event = (state_q == S_RUN) && step &&
                     (proc_end || io_wait || (quantum_q == 8'd0));

  // Rotating search: ids cur+1..n, then wrap to 1..cur, so cur comes last.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NPROC; k++) begin
      cand = 5'(cur_q) + 5'(k);
      if (cand > {1'b0, n_q}) cand = cand - {1'b0, n_q};
      if (!sel_found && (k <= int'(n_q)) && (slot_state[cand[3:0]] == SLOT_READY)) begin
        sel_found = 1'b1;
        sel_id    = cand[3:0];
      end
    end
  end

  // Table summary; descending scan leaves unblk_id on the lowest blocked slot.
  always_comb begin
    any_ready   = 1'b0;
    any_blocked = 1'b0;
    unblk_id    = '0;
    for (int i = NPROC; i >= 1; i--) begin
      if (slot_state[i] == SLOT_READY) any_ready = 1'b1;
      if (slot_state[i] == SLOT_BLOCKED) begin
        any_blocked = 1'b1;
        unblk_id    = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (n_start == 4'd0) ? S_DONE : S_SELECT;
      S_SELECT: begin
        if (sel_found)        state_d = S_DISPATCH;
        else if (any_blocked) state_d = S_WAIT;
        else                  state_d = S_DONE;
      end
      S_DISPATCH: state_d = S_RUN;
      S_RUN:      if (run_event) state_d = S_SELECT;
      // A slot may already have been unblocked while SELECT was deciding.
      S_WAIT:     if (io_done || any_ready) state_d = S_SELECT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the process table is reset too; a reset must discard every slot.
      state_q   <= S_IDLE;
      n_q       <= '0;
      cur_q     <= '0;
      proc_id_q <= '0;
      new_pc_q  <= '0;
      quantum_q <= '0;
      for (int i = 1; i <= NPROC; i++) begin
        slot_state[i] <= SLOT_FREE;
        saved_pc[i]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state_q <= state_d;

      // Unblock uses the pre-edge table, so a slot blocking this cycle is not eligible.
      if (io_done && any_blocked) slot_state[unblk_id] <= SLOT_READY;

      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            n_q   <= n_start;
            cur_q <= '0;
            for (int i = 1; i <= NPROC; i++) begin
              if (i <= int'(n_start)) begin
                slot_state[i] <= SLOT_READY;
                saved_pc[i]   <= 32'(BASE + (i - 1) * SLOT);
              end else begin
                slot_state[i] <= SLOT_FREE;
              end
            end
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            cur_q     <= sel_id;
            proc_id_q <= sel_id;
            new_pc_q  <= saved_pc[sel_id];
          end else begin
            proc_id_q <= '0;  // entering WAIT or DONE
          end
        end
        S_DISPATCH: quantum_q <= 8'(QUANTUM);
        S_RUN: begin
          if (step) begin
            if (proc_end) begin
              slot_state[cur_q] <= SLOT_FINISHED;
            end else if (io_wait) begin
              slot_state[cur_q] <= SLOT_BLOCKED;  // IN re-executes on resume
              saved_pc[cur_q]   <= pc;
            end else if (quantum_q == 8'd0) begin
              slot_state[cur_q] <= SLOT_READY;    // preempted before executing
              saved_pc[cur_q]   <= pc;
            end else begin
              quantum_q <= quantum_q - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hold       = (state_q == S_SELECT) || (state_q == S_DISPATCH) ||
                      (state_q == S_WAIT)   || run_event;
  assign switch_req = (state_q == S_DISPATCH);
  assign running    = (state_q == S_RUN);
  assign all_done   = (state_q == S_DONE);
  assign new_pc     = new_pc_q;
  assign proc_id    = proc_id_q;

`ifdef SCHED_STATS_EN
  logic [15:0] switch_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      switch_count_q <= '0;
    end else if (admit) begin
      switch_count_q <= '0;
    end else if ((state_q == S_DISPATCH) && (switch_count_q != 16'hFFFF)) begin
      switch_count_q <= switch_count_q + 16'd1;
    end
  end

  assign switch_count = switch_count_q;
`else
  assign switch_count = '0;
`endif

endmodule

// File: tb/tb_round_robin_scheduler.sv
// -----------------------------------------------------------------------------
// tb_round_robin_scheduler
//
// Randomized bench. The driver acts as the CPU: while the scheduler runs a
// process, it retires instructions at random and raises io_wait, proc_end
// and io_done at random. A process-level reference model (table of
// ready/blocked/finished processes, per-process PC, slice length) predicts
// each dispatch and each completion. The model pushes those predictions into
// a scoreboard queue. A separate monitor pops one entry whenever the DUT
// presents switch_req or raises all_done.
// -----------------------------------------------------------------------------
module tb_round_robin_scheduler;

  localparam int NPROC   = 10;
  localparam int QUANTUM = 4;
  localparam int BASE    = 300;
  localparam int SLOT    = 300;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  nproc = '0;
  logic        step = 1'b0;
  logic [31:0] pc = '0;
  logic        io_wait = 1'b0;
  logic        io_done = 1'b0;
  logic        proc_end = 1'b0;
  logic        hold;
  logic        switch_req;
  logic [31:0] new_pc;
  logic [3:0]  proc_id;
  logic        running;
  logic        all_done;
  logic [15:0] switch_count;

  round_robin_scheduler #(
    .NPROC(NPROC), .QUANTUM(QUANTUM), .BASE(BASE), .SLOT(SLOT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .nproc(nproc), .step(step),
    .pc(pc), .io_wait(io_wait), .io_done(io_done), .proc_end(proc_end),
    .hold(hold), .switch_req(switch_req), .new_pc(new_pc), .proc_id(proc_id),
    .running(running), .all_done(all_done), .switch_count(switch_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- scoreboard ----------------
  typedef enum {E_DISPATCH, E_DONE} exp_kind_e;
  typedef struct {
    exp_kind_e kind;
    int        id;
    int        pc;
    int        due;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- reference model ----------------
  typedef enum {M_FREE, M_READY, M_BLOCKED, M_FINISHED} m_state_e;
  typedef enum {PH_IDLE, PH_ACTIVE, PH_WAITING, PH_DONE} phase_e;

  m_state_e m_st  [1:NPROC];
  int       m_pc  [1:NPROC];
  int       m_lim [1:NPROC];   // instructions retired before the process ends
  int       m_n, m_cur, m_cnt, m_disp, m_wait_from;
  phase_e   m_phase = PH_IDLE;

  function automatic int start_pc(input int id);
    return BASE + (id - 1) * SLOT;
  endfunction

  function automatic bit m_any_blocked();
    for (int i = 1; i <= NPROC; i++)
      if (m_st[i] == M_BLOCKED) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_unblock();
    for (int i = 1; i <= NPROC; i++) begin
      if (m_st[i] == M_BLOCKED) begin
        m_st[i] = M_READY;
        return;
      end
    end
  endtask

  // Choose the next process after a decision point seen at cycle ev.
  task automatic m_select(input int ev);
    int   id;
    exp_t e;
    for (int j = 1; j <= m_n; j++) begin
      id = ((m_cur + j - 1) % m_n) + 1;
      if (m_st[id] == M_READY) begin
        e.kind = E_DISPATCH; e.id = id; e.pc = m_pc[id]; e.due = ev + 2;
        exp_q.push_back(e);
        m_cur   = id;
        m_cnt   = 0;
        m_disp++;
        m_phase = PH_ACTIVE;
        return;
      end
    end
    if (m_any_blocked()) begin
      m_phase     = PH_WAITING;
      m_wait_from = ev + 2 + int'($urandom_range(0, 2));
    end else begin
      e.kind = E_DONE; e.id = 0; e.pc = 0; e.due = ev + 2;
      exp_q.push_back(e);
      m_phase = PH_DONE;
    end
  endtask

  task automatic do_start(input int np);
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    nproc = 4'(np);
    m_n    = (np > NPROC) ? NPROC : np;
    m_cur  = 0;
    m_disp = 0;
    for (int i = 1; i <= NPROC; i++) begin
      if (i <= m_n) begin
        m_st[i]  = M_READY;
        m_pc[i]  = start_pc(i);
        m_lim[i] = int'($urandom_range(3, 30));
      end else begin
        m_st[i] = M_FREE;
      end
    end
    if (m_n == 0) begin
      e.kind = E_DONE; e.id = 0; e.pc = 0; e.due = cyc + 1;
      exp_q.push_back(e);
      m_phase = PH_DONE;
    end else begin
      m_select(cyc);
    end
  endtask

  // One CPU cycle, called just after a falling edge.
  task automatic drive_cycle();
    bit ev;
    start = 1'b0; step = 1'b0; io_wait = 1'b0; io_done = 1'b0; proc_end = 1'b0;
    if (m_phase == PH_WAITING) begin
      if (cyc >= m_wait_from) begin
        #1;
        check("wait_hold", hold, 1);
        check("wait_proc_id", proc_id, 0);
        check("wait_running", running, 0);
        io_done = 1'b1;
        m_unblock();
        m_select(cyc);
      end
    end else if (running) begin
      if (m_phase != PH_ACTIVE) begin
        check("unexpected_running", running, 0);
      end else begin
        check("run_proc_id", proc_id, m_cur);
        // Unblock first: a slot blocking in this same cycle is not eligible.
        if ($urandom_range(0, 7) == 0 && m_any_blocked()) begin
          io_done = 1'b1;
          m_unblock();
        end
        // start outside IDLE/DONE must be ignored.
        if ($urandom_range(0, 40) == 0) begin
          start = 1'b1;
          nproc = 4'($urandom_range(0, 15));
        end
        pc = 32'(m_pc[m_cur]);
        ev = 1'b0;
        if ($urandom_range(0, 3) != 0) begin
          step = 1'b1;
          if (m_pc[m_cur] - start_pc(m_cur) >= m_lim[m_cur]) proc_end = 1'b1;
          else if ($urandom_range(0, 9) == 0)                io_wait  = 1'b1;
          ev = proc_end || io_wait || (m_cnt == QUANTUM);
          if (proc_end)                m_st[m_cur] = M_FINISHED;
          else if (io_wait)            m_st[m_cur] = M_BLOCKED;
          else if (m_cnt == QUANTUM)   m_st[m_cur] = M_READY;
          else begin
            m_cnt++;
            m_pc[m_cur]++;
          end
        end else begin
          // Events without step have no effect.
          if ($urandom_range(0, 5) == 0) io_wait  = 1'b1;
          if ($urandom_range(0, 9) == 0) proc_end = 1'b1;
        end
        #1;
        check("run_hold", hold, 32'(ev));
        if (ev) m_select(cyc);
      end
    end
  endtask

  // Runs a session to completion, or returns early once running if stop_after > 0.
  task automatic run_session(input int np, input int stop_after);
    int budget;
    do_start(np);
    budget = 0;
    while (!(m_phase == PH_DONE && exp_q.size() == 0)) begin
      @(negedge clock);
      budget++;
      if (stop_after > 0 && budget >= stop_after && running) return;
      if (budget > 6000) begin
        fail_now("session_timeout");
        exp_q.delete();
        m_phase = PH_IDLE;
        return;
      end
      drive_cycle();
    end
    @(negedge clock);
    drive_cycle();
    #1;
    check("end_all_done", all_done, 1);
    check("end_hold", hold, 0);
    check("end_proc_id", proc_id, 0);
    check("end_running", running, 0);
`ifdef SCHED_STATS_EN
    check("end_switch_count", switch_count, 32'(m_disp));
`else
    check("end_switch_count", switch_count, 0);
`endif
  endtask

  // ---------------- monitor ----------------
  bit   prev_done = 1'b0;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && (switch_req || (all_done && !prev_done))) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {30'd0, switch_req, all_done}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_cycle", cyc, mon_e.due);
          if (mon_e.kind == E_DISPATCH) begin
            check("dispatch_switch_req", switch_req, 1);
            check("dispatch_id", proc_id, mon_e.id);
            check("dispatch_pc", new_pc, mon_e.pc);
          end else begin
            check("done_all_done", all_done, 1);
            check("done_proc_id", proc_id, 0);
            check("done_switch_req", switch_req, 0);
          end
        end
      end
      prev_done = reset ? 1'b0 : all_done;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_hold"}, hold, 0);
    check({tag, "_switch_req"}, switch_req, 0);
    check({tag, "_new_pc"}, new_pc, 0);
    check({tag, "_proc_id"}, proc_id, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_all_done"}, all_done, 0);
    check({tag, "_switch_count"}, switch_count, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    reset = 1'b0;

    run_session(0, 0);                 // n=0: straight to DONE
    run_session(2, 0);
    for (int s = 0; s < 4; s++) run_session(int'($urandom_range(1, 15)), 0);
    run_session(1, 0);                 // single process: WAIT path on io_wait
    run_session(10, 0);

    // Reset in the middle of a slice, then restart from scratch.
    run_session(3, 12);
    start = 1'b0; step = 1'b0; io_wait = 1'b0; io_done = 1'b0; proc_end = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_values("midrun_reset");
    exp_q.delete();
    m_phase = PH_IDLE;
    @(negedge clock);
    reset = 1'b0;
    run_session(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    fail_now("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_robin_scheduler.md
# round_robin_scheduler

Hardware round-robin process scheduler for the multiprogrammed CPU. It owns the process table (state plus saved PC per slot) and counts the quantum in retired instructions. It preempts on quantum expiry, blocking IN, or process end, and drives the CPU PC-load path with the next process's saved PC. It sits beside the PC register; `switch_req` and `hold` have top priority in the CPU PC mux.

## Interface
Parameters:
- `NPROC`, 10: number of process slots; ids run 1..NPROC, and id 0 means OS/none.
- `QUANTUM`, 16: instructions per time slice (1..255).
- `BASE`, 300: start PC of process 1.
- `SLOT`, 300: PC span per process; process i starts at BASE+(i-1)*SLOT.

Ports:
- `clock`, in, 1: the only clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `start`, in, 1: one-cycle pulse that admits processes and begins scheduling.
- `nproc`, in, 4: process count, sampled on `start`.
- `step`, in, 1: the CPU retires the instruction at `pc` this cycle.
- `pc`, in, 32: current CPU PC.
- `io_wait`, in, 1: the current instruction is a blocking IN.
- `io_done`, in, 1: an input is available; unblocks one process.
- `proc_end`, in, 1: the current instruction is the end-of-process instruction.
- `hold`, out, 1: combinational; the CPU must not update PC this cycle.
- `switch_req`, out, 1: one-cycle pulse; the CPU loads `new_pc`.
- `new_pc`, out, 32: saved PC of the dispatched process.
- `proc_id`, out, 4: running process (0 when none).
- `running`, out, 1: high in RUN.
- `all_done`, out, 1: every admitted process has finished.
- `switch_count`, out, 16: number of dispatches (see Configuration).

## Operation
Each slot holds a state (FREE, READY, BLOCKED, FINISHED) and a 32-bit saved PC. The scheduler has six states:

- **IDLE**
  - On `start`, slots 1..n become READY with saved PC = BASE+(i-1)*SLOT, where n = min(`nproc`, NPROC). All other slots become FREE.
  - Then go to SELECT. If n=0, go to DONE instead.
  - `start` in any state other than IDLE or DONE is ignored.
- **SELECT**
  - Rotating search over ids cur+1..n, wrapping to 1, with cur itself checked last.
  - First READY id found: go to DISPATCH.
  - No READY id but at least one BLOCKED: go to WAIT.
  - No READY and no BLOCKED: go to DONE.
- **DISPATCH**
  - Pulse `switch_req`, set `new_pc` to the slot's saved PC and `proc_id` to its id.
  - Reload the quantum counter to QUANTUM, then go to RUN.
- **RUN**
  - A cycle with `step` high and counter > 0 retires an instruction and decrements the counter.
  - Events in a `step` cycle, in priority order:
    1. `proc_end`: slot becomes FINISHED.
    2. `io_wait`: save `pc` (the IN re-executes on resume); slot becomes BLOCKED.
    3. Counter = 0: preemption; save `pc` (the instruction is not executed); slot becomes READY.
  - Any of these events goes to SELECT.
- **WAIT**
  - `proc_id`=0 while waiting for `io_done`, then go to SELECT.
- **DONE**
  - `all_done`=1. `start` re-enters the IDLE admission behaviour.

Event handling:
- `io_done` in any state marks the lowest-numbered BLOCKED slot READY. It is ignored if no slot is BLOCKED.
- If `io_done` and `io_wait` occur in the same cycle, only slots blocked before that cycle are eligible for the unblock.
- `hold` = state ∈ {SELECT, DISPATCH, WAIT}, or (RUN and `step` and any preempting event).
- `hold` = 0 in IDLE and DONE, so OS code runs freely.
- `io_wait`, `io_done` and `proc_end` are ignored outside RUN, except `io_done` as described above.

## Timing
- Reset values:
  - State IDLE; all slots FREE; cur = 0.
  - `switch_req`=0, `new_pc`=0, `proc_id`=0, `running`=0, `all_done`=0, `hold`=0, `switch_count`=0.
- `start` at cycle t: SELECT at t+1, `switch_req` at t+2, first RUN cycle at t+3.
- Preempting event at cycle t: `hold` is high at t (same cycle); `switch_req` at t+2; new process in RUN at t+3.
- A process runs exactly QUANTUM retired instructions per slice; the (QUANTUM+1)-th `step` is the preemption point.
- `proc_id` changes only in DISPATCH, and on entry to WAIT or DONE (set to 0).
- Reset asserted mid-slice returns everything to reset values immediately; the table is lost.

## Configuration
- `SCHED_STATS_EN` defined: `switch_count` increments on each DISPATCH and saturates at 65535. It clears on reset and on `start`.
- `SCHED_STATS_EN` undefined: `switch_count` is tied to 0 and no counter logic is built.

## Test plan
- QUANTUM=4, `start` with nproc=2, `step` held high:
  - `switch_req` to PC 300 (id 1).
  - After 4 steps, `hold`, then `switch_req` to 600 (id 2).
  - Then back to id 1 at the saved PC.
- nproc=2, `io_wait` asserted by id 1 at PC 305:
  - Dispatch id 2.
  - `io_done`, then at id 2's next preemption, dispatch id 1 with `new_pc`=305.
- nproc=1, `io_wait`: enter WAIT (`proc_id`=0, `hold`=1); `io_done` causes re-dispatch of id 1 at the same PC within 2 cycles.
- nproc=3, each process asserts `proc_end`: after the third, `all_done`=1, `hold`=0, `proc_id`=0.
- Reset pulsed mid-RUN: all outputs return to their reset values on the same edge; a new `start` restarts at PC 300.
- With `SCHED_STATS_EN`, nproc=2, QUANTUM=4, 20 steps: `switch_count`=5.
